// File: rtl/cl_nvdla_cfg_arb.sv
// Round-robin arbiter: one AXI4-Lite config transaction in flight, shared by NUM_REQ requesters.
// Grant and accept in the same cycle from IDLE; response held until the requester takes it; hung responses time out to SLVERR.
module cl_nvdla_cfg_arb #(
  parameter int                NUM_REQ  = 2,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_DEAD
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [NUM_REQ-1:0]        s_awvalid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] s_awaddr_i,
  output logic [NUM_REQ-1:0]        s_awready_o,
  input  logic [NUM_REQ-1:0]        s_wvalid_i,
  input  logic [NUM_REQ*DATA_W-1:0] s_wdata_i,
  output logic [NUM_REQ-1:0]        s_wready_o,
  output logic [NUM_REQ-1:0]        s_bvalid_o,
  output logic [1:0]                s_bresp_o,
  input  logic [NUM_REQ-1:0]        s_bready_i,
  input  logic [NUM_REQ-1:0]        s_arvalid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] s_araddr_i,
  output logic [NUM_REQ-1:0]        s_arready_o,
  output logic [NUM_REQ-1:0]        s_rvalid_o,
  output logic [DATA_W-1:0]         s_rdata_o,
  output logic [1:0]                s_rresp_o,
  input  logic [NUM_REQ-1:0]        s_rready_i,
  output logic                      m_awvalid_o,
  input  logic                      m_awready_i,
  output logic [ADDR_W-1:0]         m_awaddr_o,
  output logic                      m_wvalid_o,
  input  logic                      m_wready_i,
  output logic [DATA_W-1:0]         m_wdata_o,
  input  logic                      m_bvalid_i,
  output logic                      m_bready_o,
  input  logic [1:0]                m_bresp_i,
  output logic                      m_arvalid_o,
  input  logic                      m_arready_i,
  output logic [ADDR_W-1:0]         m_araddr_o,
  input  logic                      m_rvalid_i,
  output logic                      m_rready_o,
  input  logic [DATA_W-1:0]         m_rdata_i,
  input  logic [1:0]                m_rresp_i,
  output logic                      busy_o,
  output logic                      timeout_evt_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RSP, WR_RET, RD_REQ, RD_RSP, RD_RET, DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gnt_q, gnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [1:0]         resp_q, resp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic               drain_q, drain_d;
  logic               drain_wr_q, drain_wr_d;

  logic [ADDR_W-1:0]  awaddr_arr [NUM_REQ];
  logic [ADDR_W-1:0]  araddr_arr [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr  [NUM_REQ];
  logic [NUM_REQ-1:0] wr_elig, elig;
  logic [NUM_REQ-1:0] gnt_oh, cur_oh;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic               aw_fin, w_fin;
  int                 idx;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      awaddr_arr[i] = s_awaddr_i[i*ADDR_W +: ADDR_W];
      araddr_arr[i] = s_araddr_i[i*ADDR_W +: ADDR_W];
      wdata_arr[i]  = s_wdata_i[i*DATA_W +: DATA_W];
    end
    wr_elig = s_awvalid_i & s_wvalid_i;
    elig    = wr_elig | s_arvalid_i;
  end

  // First eligible requester at or after ptr, wrapping around
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
  end

  assign gnt_oh = NUM_REQ'(1) << gnt_idx;
  assign cur_oh = NUM_REQ'(1) << gnt_q;

  assign m_awaddr_o = addr_q;
  assign m_araddr_o = addr_q;
  assign m_wdata_o  = wdata_q;
  assign busy_o     = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    resp_d        = resp_q;
    cnt_d         = cnt_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    drain_d       = drain_q;
    drain_wr_d    = drain_wr_q;
    aw_fin        = 1'b0;
    w_fin         = 1'b0;
    s_awready_o   = '0;
    s_wready_o    = '0;
    s_arready_o   = '0;
    s_bvalid_o    = '0;
    s_bresp_o     = '0;
    s_rvalid_o    = '0;
    s_rdata_o     = '0;
    s_rresp_o     = '0;
    m_awvalid_o   = 1'b0;
    m_wvalid_o    = 1'b0;
    m_arvalid_o   = 1'b0;
    m_bready_o    = 1'b0;
    m_rready_o    = 1'b0;
    timeout_evt_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          gnt_d = gnt_idx;
          ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          if (wr_elig[gnt_idx]) begin
            s_awready_o = gnt_oh;
            s_wready_o  = gnt_oh;
            addr_d      = awaddr_arr[gnt_idx];
            wdata_d     = wdata_arr[gnt_idx];
            state_d     = WR_REQ;
          end else begin
            s_arready_o = gnt_oh;
            addr_d      = araddr_arr[gnt_idx];
            state_d     = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        m_awvalid_o = !aw_done_q;
        m_wvalid_o  = !w_done_q;
        aw_fin      = aw_done_q | m_awready_i;
        w_fin       = w_done_q | m_wready_i;
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          cnt_d     = '0;
          state_d   = WR_RSP;
        end else begin
          aw_done_d = aw_fin;
          w_done_d  = w_fin;
        end
      end
      RD_REQ: begin
        m_arvalid_o = 1'b1;
        if (m_arready_i) begin
          cnt_d   = '0;
          state_d = RD_RSP;
        end
      end
      // A real response in the final count cycle takes priority over the timeout
      WR_RSP: begin
        m_bready_o = 1'b1;
        if (m_bvalid_i) begin
          resp_d  = m_bresp_i;
          state_d = WR_RET;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          resp_d        = 2'b10;
          timeout_evt_o = 1'b1;
          drain_d       = 1'b1;
          drain_wr_d    = 1'b1;
          state_d       = WR_RET;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_RSP: begin
        m_rready_o = 1'b1;
        if (m_rvalid_i) begin
          resp_d  = m_rresp_i;
          rdata_d = m_rdata_i;
          state_d = RD_RET;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          resp_d        = 2'b10;
          rdata_d       = ERR_DATA;
          timeout_evt_o = 1'b1;
          drain_d       = 1'b1;
          drain_wr_d    = 1'b0;
          state_d       = RD_RET;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR_RET: begin
        s_bvalid_o = cur_oh;
        s_bresp_o  = resp_q;
        if (s_bready_i[gnt_q]) state_d = drain_q ? DRAIN : IDLE;
      end
      RD_RET: begin
        s_rvalid_o = cur_oh;
        s_rresp_o  = resp_q;
        s_rdata_o  = rdata_q;
        if (s_rready_i[gnt_q]) state_d = drain_q ? DRAIN : IDLE;
      end
      DRAIN: begin
        m_bready_o = drain_wr_q;
        m_rready_o = !drain_wr_q;
        if (drain_wr_q ? m_bvalid_i : m_rvalid_i) begin
          drain_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      resp_q     <= '0;
      cnt_q      <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      drain_q    <= 1'b0;
      drain_wr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
      cnt_q      <= cnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      drain_q    <= drain_d;
      drain_wr_q <= drain_wr_d;
    end
  end

endmodule
